serial_rx_fifo: RTL and testbench

//  Byte FIFO directly downstream of the 9600-baud serial receiver. Captures each received byte
//  on the receiver's one-cycle byte-ready strobe and holds it until the consumer reads it.

---
 rtl/serial_rx_fifo.sv | 107 ++++++++++
 tb/tb_serial_rx_fifo.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx_fifo.sv
// rtl/serial_rx_fifo.sv - byte FIFO behind the serial receiver with occupancy and overflow flag
// Optional: define RX_FIFO_DROP_CNT_EN to add the saturating DROP_CNT_O drop counter.
module serial_rx_fifo #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              CLK_100_I,
  input  logic              RST_I,
  input  logic [DATA_W-1:0] WR_BYTE_I,
  input  logic              WR_EN_I,
  input  logic              RD_EN_I,
  output logic [DATA_W-1:0] RD_BYTE_O,
  output logic              RD_VALID_O,
  output logic              EMPTY_O,
  output logic              FULL_O,
  output logic [ADDR_W:0]   COUNT_O,
  output logic              OVERFLOW_O,
`ifdef RX_FIFO_DROP_CNT_EN
  output logic [7:0]        DROP_CNT_O,
`endif
  input  logic              CLR_OVF_I
);

  localparam int              DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] C_DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_rd_byte;
  logic              r_rd_valid;
  logic              r_ovf;

  logic w_empty;
  logic w_full;
  logic w_do_rd;
  logic w_do_wr;
  logic w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == C_DEPTH);
  assign w_do_rd = RD_EN_I && !w_empty;
  // A pop in the same cycle frees the slot the write lands in, so a full FIFO still accepts it.
  assign w_do_wr = WR_EN_I && (!w_full || w_do_rd);
  assign w_drop  = WR_EN_I && !w_do_wr;

  always_ff @(posedge CLK_100_I) begin
    if (w_do_wr) begin
      r_mem[r_wptr] <= WR_BYTE_I;
    end
  end

  always_ff @(posedge CLK_100_I) begin
    if (RST_I) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_rd_byte  <= '0;
      r_rd_valid <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_rd_valid <= w_do_rd;
      if (w_do_rd) begin
        r_rd_byte <= r_mem[r_rptr];
        r_rptr    <= r_rptr + ADDR_W'(1);
      end
      if (w_do_wr) begin
        r_wptr <= r_wptr + ADDR_W'(1);
      end
      if (w_do_wr && !w_do_rd) begin
        r_count <= r_count + (ADDR_W + 1)'(1);
      end else if (w_do_rd && !w_do_wr) begin
        r_count <= r_count - (ADDR_W + 1)'(1);
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (CLR_OVF_I) begin
        r_ovf <= 1'b0;
      end
    end
  end

`ifdef RX_FIFO_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge CLK_100_I) begin
    if (RST_I) begin
      r_drop_cnt <= '0;
    end else if (CLR_OVF_I) begin
      r_drop_cnt <= w_drop ? 8'd1 : 8'd0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign DROP_CNT_O = r_drop_cnt;
`endif

  assign RD_BYTE_O  = r_rd_byte;
  assign RD_VALID_O = r_rd_valid;
  assign EMPTY_O    = w_empty;
  assign FULL_O     = w_full;
  assign COUNT_O    = r_count;
  assign OVERFLOW_O = r_ovf;

endmodule

// File: tb/tb_serial_rx_fifo.sv
// tb/tb_serial_rx_fifo.sv - self-checking bench for serial_rx_fifo against a queue model
module tb_serial_rx_fifo;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] wr_byte = '0;
  logic              wr_en = 1'b0;
  logic              rd_en = 1'b0;
  logic              clr = 1'b0;
  logic [DATA_W-1:0] rd_byte;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              ovf;
`ifdef RX_FIFO_DROP_CNT_EN
  logic [7:0]        drop_cnt;
`endif

  always #5 clk = ~clk;

  serial_rx_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK_100_I (clk),
    .RST_I     (rst),
    .WR_BYTE_I (wr_byte),
    .WR_EN_I   (wr_en),
    .RD_EN_I   (rd_en),
    .RD_BYTE_O (rd_byte),
    .RD_VALID_O(rd_valid),
    .EMPTY_O   (empty),
    .FULL_O    (full),
    .COUNT_O   (count),
    .OVERFLOW_O(ovf),
`ifdef RX_FIFO_DROP_CNT_EN
    .DROP_CNT_O(drop_cnt),
`endif
    .CLR_OVF_I (clr)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] q[$];
  logic       m_valid = 1'b0;
  logic [7:0] m_byte  = 8'h00;
  logic       m_ovf   = 1'b0;
  int         m_dc    = 0;

  // Drive one clock of stimulus and advance the reference model by the FIFO's rules.
  task automatic cycle(input logic w, input logic [7:0] b, input logic r, input logic c, input logic rs);
    logic do_rd;
    logic accept;
    logic drop;
    wr_en = w; wr_byte = b; rd_en = r; clr = c; rst = rs;
    @(posedge clk);
    #1;
    if (rs) begin
      q.delete();
      m_valid = 1'b0; m_byte = 8'h00; m_ovf = 1'b0; m_dc = 0;
    end else begin
      do_rd  = r && (q.size() > 0);
      accept = w && ((q.size() < DEPTH) || do_rd);
      drop   = w && !accept;
      m_valid = do_rd;
      if (do_rd) m_byte = q.pop_front();
      if (accept) q.push_back(b);
      if (drop) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
      if (c) m_dc = drop ? 1 : 0;
      else if (drop && m_dc < 255) m_dc = m_dc + 1;
    end
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    n_total++; if (rd_byte !== 8'h00) $display("FAIL reset_rd_byte got=%h exp=00", rd_byte); else n_pass++;
    n_total++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", empty); else n_pass++;
    n_total++; if (full !== 1'b0) $display("FAIL reset_full got=%b exp=0", full); else n_pass++;
    n_total++; if (count !== 5'd0) $display("FAIL reset_count got=%0d exp=0", count); else n_pass++;
    n_total++; if (ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", ovf); else n_pass++;
`ifdef RX_FIFO_DROP_CNT_EN
    n_total++; if (drop_cnt !== 8'd0) $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); else n_pass++;
`endif
  endtask

  task automatic test_basic();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
    for (int i = 0; i < 3; i++) cycle(1'b1, exp_b[i], 1'b0, 1'b0, 1'b0);
    n_total++; if (count !== 5'd3) $display("FAIL basic_count got=%0d exp=3", count); else n_pass++;
    n_total++; if (empty !== 1'b0) $display("FAIL basic_empty got=%b exp=0", empty); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      n_total++; if (rd_valid !== 1'b1) $display("FAIL basic_valid[%0d] got=%b exp=1", i, rd_valid); else n_pass++;
      n_total++; if (rd_byte !== exp_b[i]) $display("FAIL basic_byte[%0d] got=%h exp=%h", i, rd_byte, exp_b[i]); else n_pass++;
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_total++; if (rd_valid !== 1'b0) $display("FAIL basic_valid_idle got=%b exp=0", rd_valid); else n_pass++;
    n_total++; if (count !== 5'd0) $display("FAIL basic_count_end got=%0d exp=0", count); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL basic_empty_end got=%b exp=1", empty); else n_pass++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    n_total++; if (full !== 1'b1) $display("FAIL ovf_full got=%b exp=1", full); else n_pass++;
    n_total++; if (count !== 5'd16) $display("FAIL ovf_count got=%0d exp=16", count); else n_pass++;
    cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    n_total++; if (ovf !== 1'b1) $display("FAIL ovf_flag got=%b exp=1", ovf); else n_pass++;
    n_total++; if (count !== 5'd16) $display("FAIL ovf_count_after got=%0d exp=16", count); else n_pass++;
`ifdef RX_FIFO_DROP_CNT_EN
    n_total++; if (drop_cnt !== 8'd1) $display("FAIL ovf_drop_cnt got=%0d exp=1", drop_cnt); else n_pass++;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      n_total++; if (rd_valid !== 1'b1 || rd_byte !== 8'(i)) $display("FAIL ovf_read[%0d] got=%b/%h exp=1/%h", i, rd_valid, rd_byte, 8'(i)); else n_pass++;
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_total++; if (rd_valid !== 1'b0) $display("FAIL ovf_no_aa got=%b/%h exp=0", rd_valid, rd_byte); else n_pass++;
    n_total++; if (ovf !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", ovf); else n_pass++;
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    n_total++; if (ovf !== 1'b0) $display("FAIL ovf_clear got=%b exp=0", ovf); else n_pass++;
`ifdef RX_FIFO_DROP_CNT_EN
    n_total++; if (drop_cnt !== 8'd0) $display("FAIL ovf_drop_cnt_clear got=%0d exp=0", drop_cnt); else n_pass++;
`endif
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    n_total++; if (rd_valid !== 1'b1 || rd_byte !== 8'h00) $display("FAIL full_rw_read got=%b/%h exp=1/00", rd_valid, rd_byte); else n_pass++;
    n_total++; if (ovf !== 1'b0) $display("FAIL full_rw_ovf got=%b exp=0", ovf); else n_pass++;
    n_total++; if (count !== 5'd16) $display("FAIL full_rw_count got=%0d exp=16", count); else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      n_total++; if (rd_valid !== 1'b1 || rd_byte !== m_byte) $display("FAIL full_rw_drain[%0d] got=%b/%h exp=1/%h", i, rd_valid, rd_byte, m_byte); else n_pass++;
    end
    n_total++; if (rd_byte !== 8'h55) $display("FAIL full_rw_last got=%h exp=55", rd_byte); else n_pass++;
  endtask

  task automatic test_empty();
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_total++; if (rd_valid !== 1'b0) $display("FAIL empty_rd_valid got=%b exp=0", rd_valid); else n_pass++;
    n_total++; if (count !== 5'd0) $display("FAIL empty_rd_count got=%0d exp=0", count); else n_pass++;
    n_total++; if (rd_byte !== 8'h55) $display("FAIL empty_rd_hold got=%h exp=55", rd_byte); else n_pass++;
    cycle(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
    n_total++; if (count !== 5'd1) $display("FAIL empty_rw_count got=%0d exp=1", count); else n_pass++;
    n_total++; if (rd_valid !== 1'b0) $display("FAIL empty_rw_valid got=%b exp=0", rd_valid); else n_pass++;
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_total++; if (rd_valid !== 1'b1 || rd_byte !== 8'h99) $display("FAIL empty_rw_next got=%b/%h exp=1/99", rd_valid, rd_byte); else n_pass++;
  endtask

  task automatic test_wrap();
    int max_count = 0;
    for (int i = 0; i < 40; i++) begin
      if ((i % 2) == 0) begin
        cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      end else begin
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_total++; if (rd_valid !== 1'b1 || rd_byte !== 8'(i - 1)) $display("FAIL wrap_read[%0d] got=%b/%h exp=1/%h", i, rd_valid, rd_byte, 8'(i - 1)); else n_pass++;
      end
      if (int'(count) > max_count) max_count = int'(count);
    end
    n_total++; if (max_count > 1) $display("FAIL wrap_max_count got=%0d exp<=1", max_count); else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    n_total++; if (count !== 5'd5) $display("FAIL mid_fill_count got=%0d exp=5", count); else n_pass++;
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    n_total++; if (count !== 5'd0) $display("FAIL mid_rst_count got=%0d exp=0", count); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL mid_rst_empty got=%b exp=1", empty); else n_pass++;
    n_total++; if (ovf !== 1'b0) $display("FAIL mid_rst_ovf got=%b exp=0", ovf); else n_pass++;
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_total++; if (rd_valid !== 1'b0) $display("FAIL mid_rst_read got=%b exp=0", rd_valid); else n_pass++;
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    n_total++; if (ovf !== 1'b1) $display("FAIL drop_clr_ovf got=%b exp=1", ovf); else n_pass++;
`ifdef RX_FIFO_DROP_CNT_EN
    n_total++; if (drop_cnt !== 8'd1) $display("FAIL drop_clr_cnt got=%0d exp=1", drop_cnt); else n_pass++;
`endif
  endtask

  task automatic test_random();
    int wp;
    int rp;
    for (int i = 0; i < 500; i++) begin
      // Alternate fill-heavy and drain-heavy phases so full, empty and overflow are all reached.
      wp = ((i / 50) % 2 == 0) ? 80 : 30;
      rp = ((i / 50) % 2 == 0) ? 25 : 75;
      cycle($urandom_range(99) < wp, 8'($urandom), $urandom_range(99) < rp,
            $urandom_range(99) < 5, $urandom_range(199) == 0);
      n_total++; if (rd_valid !== m_valid) $display("FAIL rand_valid[%0d] got=%b exp=%b", i, rd_valid, m_valid); else n_pass++;
      n_total++; if (rd_byte !== m_byte) $display("FAIL rand_byte[%0d] got=%h exp=%h", i, rd_byte, m_byte); else n_pass++;
      n_total++; if (count !== 5'(q.size())) $display("FAIL rand_count[%0d] got=%0d exp=%0d", i, count, q.size()); else n_pass++;
      n_total++; if (empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) $display("FAIL rand_flags[%0d] got=%b%b exp=%b%b", i, empty, full, q.size() == 0, q.size() == DEPTH); else n_pass++;
      n_total++; if (ovf !== m_ovf) $display("FAIL rand_ovf[%0d] got=%b exp=%b", i, ovf, m_ovf); else n_pass++;
`ifdef RX_FIFO_DROP_CNT_EN
      n_total++; if (drop_cnt !== 8'(m_dc)) $display("FAIL rand_drop_cnt[%0d] got=%0d exp=%0d", i, drop_cnt, m_dc); else n_pass++;
`endif
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_rw();
    test_empty();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
